// File: rtl/az_sequencer.sv
// az_sequencer: measurement sequencer sitting between the SPI register bank
// and the AZ modulator. On start it latches mode, channel selects and the
// cycle count, arms the azmux selects, enables the modulator and counts
// completed sample cycles until nsamples is reached (or forever when
// nsamples is 0), an abort arrives, or the watchdog expires.
//
// Pulse interface: start, abort and sample_done are single-cycle pulses
// sampled on the rising clock edge; there is no back-pressure. sample_sel
// is only meaningful in a cycle where sample_done is high (1 = hi phase,
// 0 = lo phase). start is accepted only in IDLE; abort wins over start.
//
// Build option: define AZSEQ_MONITOR_EN to add the registered 8-bit
// 'monitor' output ({state, err, done, phase_id[1], sample_sel,
// sample_done, mod_run}). Without it the port and its register are absent.
module az_sequencer #(
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 40000000,
    parameter int MUX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [MUX_W-1:0] chan_hi,
    input  logic [MUX_W-1:0] chan_lo,
    input  logic [MUX_W-1:0] chan_ref,
    input  logic [CNT_W-1:0] nsamples,
    input  logic             sample_done,
    input  logic             sample_sel,
    output logic             mod_run,
    output logic [MUX_W-1:0] azmux_hi_val,
    output logic [MUX_W-1:0] azmux_lo_val,
    output logic [1:0]       phase_id,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef AZSEQ_MONITOR_EN
    ,
    output logic [7:0]       monitor
`endif
);

    // Watchdog counter is wide enough to hold WDOG_CYCLES-1.
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    // Mode encodings; 3 is reserved and falls through to AZ behaviour
    // because only NOAZ and RATIO are ever decoded explicitly.
    localparam logic [1:0] MODE_NOAZ  = 2'd0;
    localparam logic [1:0] MODE_RATIO = 2'd2;

    // Source of the next hi sample.
    localparam logic [1:0] PH_HI  = 2'd0;
    localparam logic [1:0] PH_REF = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [1:0]        mode_q,     mode_d;
    logic [MUX_W-1:0]  chan_hi_q,  chan_hi_d;
    logic [MUX_W-1:0]  chan_ref_q, chan_ref_d;
    logic [CNT_W-1:0]  nsamp_q,    nsamp_d;
    logic              mod_run_q,  mod_run_d;
    logic [MUX_W-1:0]  hi_val_q,   hi_val_d;
    logic [MUX_W-1:0]  lo_val_q,   lo_val_d;
    logic [1:0]        phase_q,    phase_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              err_q,      err_d;
    logic [WDOG_W-1:0] wdog_q,     wdog_d;

    // Helper values used by the next-state logic.
    logic [CNT_W-1:0]  count_inc;
    logic              lo_pulse;
    logic              ratio_to_ref;

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            chan_hi_q  <= '0;
            chan_ref_q <= '0;
            nsamp_q    <= '0;
            mod_run_q  <= 1'b0;
            hi_val_q   <= '0;
            lo_val_q   <= '0;
            phase_q    <= PH_HI;
            count_q    <= '0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            chan_hi_q  <= chan_hi_d;
            chan_ref_q <= chan_ref_d;
            nsamp_q    <= nsamp_d;
            mod_run_q  <= mod_run_d;
            hi_val_q   <= hi_val_d;
            lo_val_q   <= lo_val_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
        end
    end

    // Next-state logic: sequencing, cycle counting, select rotation and watchdog.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        chan_hi_d    = chan_hi_q;
        chan_ref_d   = chan_ref_q;
        nsamp_d      = nsamp_q;
        mod_run_d    = mod_run_q;
        hi_val_d     = hi_val_q;
        lo_val_d     = lo_val_q;
        phase_d      = phase_q;
        count_d      = count_q;
        err_d        = err_q;
        wdog_d       = wdog_q;

        count_inc    = count_q + CNT_W'(1);
        lo_pulse     = sample_done & ~sample_sel;
        // In RATIO the first lo phase of a cycle only swaps hi to the reference.
        ratio_to_ref = (mode_q == MODE_RATIO) && (phase_q == PH_HI);

        case (state_q)
            S_IDLE: begin
                // sample_done is deliberately ignored here.
                if (start && !abort) begin
                    mode_d     = mode;
                    chan_hi_d  = chan_hi;
                    chan_ref_d = chan_ref;
                    nsamp_d    = nsamples;
                    count_d    = '0;
                    err_d      = 1'b0;
                    phase_d    = PH_HI;
                    // Selects are driven from ARM onwards so they are stable
                    // for a full clock before mod_run rises.
                    hi_val_d   = chan_hi;
                    lo_val_d   = (mode == MODE_NOAZ) ? chan_hi : chan_lo;
                    state_d    = S_ARM;
                end
            end

            S_ARM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    mod_run_d = 1'b1;
                    wdog_d    = '0;
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Count holds its value; no done pulse.
                    mod_run_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (sample_done) begin
                    // Any sample phase, hi or lo, proves the modulator is alive.
                    wdog_d = '0;
                    if (lo_pulse) begin
                        if (ratio_to_ref) begin
                            phase_d  = PH_REF;
                            hi_val_d = chan_ref_q;
                        end else begin
                            if (mode_q == MODE_RATIO) begin
                                phase_d  = PH_HI;
                                hi_val_d = chan_hi_q;
                            end
                            // Continuous runs (nsamples 0) wrap naturally.
                            count_d = count_inc;
                            if ((nsamp_q != '0) && (count_inc == nsamp_q)) begin
                                mod_run_d = 1'b0;
                                state_d   = S_FINISH;
                            end
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // WDOG_CYCLES clocks have passed since the last pulse.
                    err_d     = 1'b1;
                    mod_run_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end

            S_FINISH: begin
                // done is decoded from this state; selects keep their values.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output drive: status flags decode straight from the state register.
    assign mod_run      = mod_run_q;
    assign azmux_hi_val = hi_val_q;
    assign azmux_lo_val = lo_val_q;
    assign phase_id     = phase_q;
    assign count        = count_q;
    assign err          = err_q;
    assign busy         = (state_q == S_ARM) || (state_q == S_RUN);
    assign done         = (state_q == S_FINISH);

`ifdef AZSEQ_MONITOR_EN
    logic [7:0] monitor_q;

    // Registered snapshot of the run's key signals for external observation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            monitor_q <= '0;
        end else begin
            monitor_q <= {state_q, err_q, done, phase_q[1],
                          sample_sel, sample_done, mod_run_q};
        end
    end

    assign monitor = monitor_q;
`endif

endmodule

// File: tb/tb_az_sequencer.sv
// tb_az_sequencer: self-checking bench for az_sequencer. Expected values come
// from a cycle-level view of the measurement rules: a run needs n cycles of
// lo pulses (2n in RATIO), the hi select alternates with every lo pulse in
// RATIO, and everything else holds between pulses.
module tb_az_sequencer;

    localparam int CNT_W = 16;
    localparam int MUX_W = 4;
    localparam int WDOG  = 100;
    localparam int SB_W  = CNT_W + MUX_W + 2;

    // Clock and reset.
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT inputs.
    logic             start       = 1'b0;
    logic             abort       = 1'b0;
    logic [1:0]       mode        = '0;
    logic [MUX_W-1:0] chan_hi     = '0;
    logic [MUX_W-1:0] chan_lo     = '0;
    logic [MUX_W-1:0] chan_ref    = '0;
    logic [CNT_W-1:0] nsamples    = '0;
    logic             sample_done = 1'b0;
    logic             sample_sel  = 1'b0;

    // DUT outputs.
    logic             mod_run;
    logic [MUX_W-1:0] azmux_hi_val;
    logic [MUX_W-1:0] azmux_lo_val;
    logic [1:0]       phase_id;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    // Scoreboard: expected {count, hi_val, phase_id} after each lo pulse.
    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    az_sequencer #(
        .CNT_W      (CNT_W),
        .WDOG_CYCLES(WDOG),
        .MUX_W      (MUX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .chan_hi     (chan_hi),
        .chan_lo     (chan_lo),
        .chan_ref    (chan_ref),
        .nsamples    (nsamples),
        .sample_done (sample_done),
        .sample_sel  (sample_sel),
        .mod_run     (mod_run),
        .azmux_hi_val(azmux_hi_val),
        .azmux_lo_val(azmux_lo_val),
        .phase_id    (phase_id),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle modulator pulse of the given phase.
    task automatic pulse(input logic sel);
        sample_done = 1'b1;
        sample_sel  = sel;
        tick();
        sample_done = 1'b0;
        sample_sel  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({mod_run, azmux_hi_val, azmux_lo_val, phase_id, count, busy, done, err} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {mod_run, azmux_hi_val, azmux_lo_val, phase_id, count, busy, done, err});
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || mod_run !== 1'b0)
            $display("FAIL reset_release_idle: got busy=%b mod_run=%b want 0 0", busy, mod_run);
        else n_pass++;
    endtask

    // Full run from start to done; alternate=1 gives a strict hi,lo,hi,lo
    // modulator, alternate=0 gives random gaps and optional hi phases.
    task automatic run_scenario(input string tag, input logic [1:0] m,
                                input logic [MUX_W-1:0] h, input logic [MUX_W-1:0] l,
                                input logic [MUX_W-1:0] r, input logic [CNT_W-1:0] n,
                                input bit alternate);
        logic [MUX_W-1:0] exp_lo;
        logic [SB_W-1:0]  e;
        logic [SB_W-1:0]  last;
        bit               ratio;
        bit               last_done;
        int               total_lo;
        int               gap;
        ratio    = (m == 2'd2);
        exp_lo   = (m == 2'd0) ? h : l;
        total_lo = ratio ? 2 * int'(n) : int'(n);
        exp_q.delete();
        for (int k = 1; k <= total_lo; k++) begin
            logic [CNT_W-1:0] c;
            logic [1:0]       p;
            c = CNT_W'(ratio ? k / 2 : k);
            p = (ratio && (k % 2 == 1)) ? 2'd2 : 2'd0;
            exp_q.push_back({c, (p == 2'd2) ? r : h, p});
        end

        mode = m; chan_hi = h; chan_lo = l; chan_ref = r; nsamples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble the inputs: the run must use the latched copies.
        chan_hi = ~h; chan_lo = ~l; chan_ref = ~r;
        mode = 2'($urandom); nsamples = CNT_W'($urandom);

        n_checks++;
        if ({busy, mod_run, azmux_hi_val, azmux_lo_val, count} !== {1'b1, 1'b0, h, exp_lo, {CNT_W{1'b0}}})
            $display("FAIL %s arm: got busy=%b run=%b hi=%h lo=%h cnt=%0d want 1 0 %h %h 0",
                     tag, busy, mod_run, azmux_hi_val, azmux_lo_val, count, h, exp_lo);
        else n_pass++;
        tick();
        n_checks++;
        if (mod_run !== 1'b1)
            $display("FAIL %s mod_run_rise: got %b want 1", tag, mod_run);
        else n_pass++;

        last = {{CNT_W{1'b0}}, h, 2'd0};
        while (exp_q.size() > 0) begin
            gap = alternate ? 0 : $urandom_range(0, 2);
            repeat (gap) tick();
            if (alternate || $urandom_range(0, 1) == 1) pulse(1'b1);
            n_checks++;
            if ({count, azmux_hi_val, phase_id} !== last || mod_run !== 1'b1)
                $display("FAIL %s hold: got %h run=%b want %h run=1",
                         tag, {count, azmux_hi_val, phase_id}, mod_run, last);
            else n_pass++;

            pulse(1'b0);
            e = exp_q.pop_front();
            last_done = (exp_q.size() == 0);
            n_checks++;
            if ({count, azmux_hi_val, phase_id} !== e || azmux_lo_val !== exp_lo)
                $display("FAIL %s lo_pulse: got cnt=%0d hi=%h ph=%0d lo=%h want %h lo=%h",
                         tag, count, azmux_hi_val, phase_id, azmux_lo_val, e, exp_lo);
            else n_pass++;
            n_checks++;
            if (mod_run !== !last_done || done !== last_done)
                $display("FAIL %s run_done: got run=%b done=%b want %b %b",
                         tag, mod_run, done, !last_done, last_done);
            else n_pass++;
            last = e;
        end

        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || azmux_hi_val !== h || count !== n)
            $display("FAIL %s after_done: got done=%b busy=%b hi=%h cnt=%0d want 0 0 %h %0d",
                     tag, done, busy, azmux_hi_val, count, h, n);
        else n_pass++;
    endtask

    task automatic test_directed_modes();
        run_scenario("az",    2'd1, 4'd8, 4'd2, 4'd0, 16'd3, 1'b1);
        run_scenario("ratio", 2'd2, 4'd8, 4'd2, 4'd5, 16'd2, 1'b1);
        run_scenario("noaz",  2'd0, 4'd8, 4'd2, 4'd0, 16'd4, 1'b1);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 10; i++) begin
            logic [1:0]       m;
            logic [MUX_W-1:0] h, l, r;
            logic [CNT_W-1:0] n;
            m = 2'($urandom_range(0, 3));
            h = MUX_W'($urandom);
            l = MUX_W'($urandom);
            r = MUX_W'($urandom);
            n = CNT_W'($urandom_range(1, 4));
            run_scenario("rand", m, h, l, r, n, 1'b0);
        end
    endtask

    task automatic test_continuous_wrap();
        bit done_seen;
        done_seen = 1'b0;
        mode = 2'd1; chan_hi = 4'd8; chan_lo = 4'd2; nsamples = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sample_done = 1'b1;
        sample_sel  = 1'b0;
        repeat (70000) begin
            tick();
            done_seen = done_seen | done;
        end
        sample_done = 1'b0;
        n_checks++;
        if (count !== 16'd4464 || mod_run !== 1'b1 || done_seen !== 1'b0)
            $display("FAIL wrap_count: got cnt=%0d run=%b done_seen=%b want 4464 1 0",
                     count, mod_run, done_seen);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (mod_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 16'd4464)
            $display("FAIL wrap_abort: got run=%b busy=%b done=%b cnt=%0d want 0 0 0 4464",
                     mod_run, busy, done, count);
        else n_pass++;
        done_seen = 1'b0;
        repeat (3) begin
            tick();
            done_seen = done_seen | done;
        end
        n_checks++;
        if (done_seen !== 1'b0 || count !== 16'd4464)
            $display("FAIL wrap_after_abort: got done_seen=%b cnt=%0d want 0 4464", done_seen, count);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        mode = 2'd1; chan_hi = 4'd8; chan_lo = 4'd2; nsamples = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pulse(1'b0);
        n_checks++;
        if (count !== 16'd1)
            $display("FAIL wdog_first_pulse: got cnt=%0d want 1", count);
        else n_pass++;
        repeat (WDOG - 1) tick();
        n_checks++;
        if (mod_run !== 1'b1 || err !== 1'b0)
            $display("FAIL wdog_early: got run=%b err=%b want 1 0", mod_run, err);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1 || mod_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL wdog_trip: got err=%b run=%b busy=%b done=%b want 1 0 0 0",
                     err, mod_run, busy, done);
        else n_pass++;
        repeat (2) tick();
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0)
            $display("FAIL wdog_sticky: got err=%b done=%b want 1 0", err, done);
        else n_pass++;
        // A new start clears err; abort it while still in ARM.
        nsamples = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL wdog_clear: got err=%b busy=%b want 0 1", err, busy);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        n_checks++;
        if (mod_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL arm_abort: got run=%b busy=%b done=%b want 0 0 0", mod_run, busy, done);
        else n_pass++;
    endtask

    task automatic test_start_abort_same();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mod_run !== 1'b0)
            $display("FAIL start_abort: got busy=%b run=%b want 0 0", busy, mod_run);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || mod_run !== 1'b0)
            $display("FAIL start_abort_later: got busy=%b run=%b want 0 0", busy, mod_run);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        mode = 2'd1; chan_hi = 4'd8; chan_lo = 4'd2; chan_ref = 4'd0; nsamples = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mode = 2'd2; chan_hi = 4'd3; chan_lo = 4'd6; chan_ref = 4'd9; nsamples = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (azmux_hi_val !== 4'd8 || azmux_lo_val !== 4'd2 || busy !== 1'b1 || mod_run !== 1'b1)
            $display("FAIL busy_start: got hi=%h lo=%h busy=%b run=%b want 8 2 1 1",
                     azmux_hi_val, azmux_lo_val, busy, mod_run);
        else n_pass++;
        pulse(1'b0);
        n_checks++;
        if (count !== 16'd1 || mod_run !== 1'b1 || done !== 1'b0 || phase_id !== 2'd0)
            $display("FAIL busy_first: got cnt=%0d run=%b done=%b ph=%0d want 1 1 0 0",
                     count, mod_run, done, phase_id);
        else n_pass++;
        pulse(1'b0);
        n_checks++;
        if (count !== 16'd2 || done !== 1'b1 || azmux_hi_val !== 4'd8)
            $display("FAIL busy_second: got cnt=%0d done=%b hi=%h want 2 1 8", count, done, azmux_hi_val);
        else n_pass++;
        tick();
    endtask

    task automatic test_idle_inputs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulse(1'b0);
        pulse(1'b1);
        n_checks++;
        if (count !== 16'd2 || busy !== 1'b0 || mod_run !== 1'b0 || azmux_hi_val !== 4'd8)
            $display("FAIL idle_ignore: got cnt=%0d busy=%b run=%b hi=%h want 2 0 0 8",
                     count, busy, mod_run, azmux_hi_val);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        mode = 2'd2; chan_hi = 4'd8; chan_lo = 4'd2; chan_ref = 4'd5; nsamples = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pulse(1'b0);
        n_checks++;
        if (phase_id !== 2'd2 || azmux_hi_val !== 4'd5 || mod_run !== 1'b1)
            $display("FAIL pre_reset: got ph=%0d hi=%h run=%b want 2 5 1", phase_id, azmux_hi_val, mod_run);
        else n_pass++;
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({mod_run, azmux_hi_val, azmux_lo_val, phase_id, count, busy, done, err} !== '0)
            $display("FAIL async_reset: got %h want 0",
                     {mod_run, azmux_hi_val, azmux_lo_val, phase_id, count, busy, done, err});
        else n_pass++;
        #2 reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || mod_run !== 1'b0)
            $display("FAIL after_reset: got busy=%b run=%b want 0 0", busy, mod_run);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed_modes();
        test_random_runs();
        test_start_abort_same();
        test_start_while_busy();
        test_idle_inputs();
        test_watchdog();
        test_continuous_wrap();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
